// File: rtl/handshake_ram.sv
// handshake_ram: byte-addressed big-endian RAM behind a mov/mfa handshake.
// Each beat waits WAIT_CYCLES cycles and is then acknowledged with mfa.
// A doubleword is split into two word beats, with a one-cycle mfa pulse
// between them. A byte-wide preload port fills memory while the FSM is idle.
module handshake_ram #(
   parameter int unsigned ADDR_WIDTH  = 9,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                  main_clk,
   input  logic                  reset,
   input  logic                  mov,
   input  logic                  rw,
   input  logic [1:0]            size,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [31:0]           data_in,
   output logic [31:0]           data_out,
   output logic                  mfa,
   output logic                  err,
   input  logic                  load_valid,
   input  logic [7:0]            load_byte,
   output logic                  load_ready
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StAck1,
      StWait2,
      StAck
   } state_t;

   state_t                 state;
   logic [3:0]             wait_cnt;
   logic                   lat_rw;
   logic [1:0]             lat_size;
   logic [ADDR_WIDTH-1:0]  lat_addr;
   logic [31:0]            lat_data;
   logic [ADDR_WIDTH-1:0]  load_ptr;

   logic [7:0]             mem [DEPTH];

   logic                   beat_fire;
   logic                   misaligned;
   logic                   load_fire;
   logic [ADDR_WIDTH-1:0]  beat_addr;
   logic [3:0]             wr_mask;
   logic [3:0]             wr_en;
   logic [3:0][7:0]        wr_byte;
   logic [3:0][7:0]        rd_byte;
   logic [ADDR_WIDTH-1:0]  byte_addr [4];
   logic [31:0]            rd_word;

   // The preload port only runs while idle with no request pending.
   assign load_ready = (state == StIdle) && !mov && !reset;
   assign load_fire  = load_valid && load_ready;

   // A beat executes on the edge where the wait counter has reached zero;
   // gating with reset makes a reset on that edge abandon the beat.
   assign beat_fire = ((state == StWait) || (state == StWait2)) && (wait_cnt == 4'd0) && !reset;

   // Alignment is judged on the request address; the second doubleword
   // beat is aligned whenever the first one was.
   always_comb begin
      misaligned = 1'b0;
      unique case (lat_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = lat_addr[0];
         2'b10:   misaligned = |lat_addr[1:0];
         default: misaligned = |lat_addr[2:0];
      endcase
   end

   // Beat address, per-byte addresses (wrapping modulo DEPTH) and read data.
   always_comb begin
      beat_addr = (state == StWait2) ? lat_addr + ADDR_WIDTH'(4) : lat_addr;
      for (int i = 0; i < 4; i++) begin
         byte_addr[i] = beat_addr + ADDR_WIDTH'(i);
         rd_byte[i]   = mem[byte_addr[i]];
      end
      unique case (lat_size)
         2'b00:   rd_word = {24'h000000, rd_byte[0]};
         2'b01:   rd_word = {16'h0000, rd_byte[0], rd_byte[1]};
         default: rd_word = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
      endcase
   end

   // Big-endian write lanes: byte 0 of the beat takes the most significant
   // byte of the right-justified write data.
   always_comb begin
      wr_byte[3] = lat_data[7:0];
      wr_byte[2] = lat_data[15:8];
      wr_byte[1] = (lat_size == 2'b01) ? lat_data[7:0] : lat_data[23:16];
      unique case (lat_size)
         2'b00:   wr_byte[0] = lat_data[7:0];
         2'b01:   wr_byte[0] = lat_data[15:8];
         default: wr_byte[0] = lat_data[31:24];
      endcase
      unique case (lat_size)
         2'b00:   wr_mask = 4'b0001;
         2'b01:   wr_mask = 4'b0011;
         default: wr_mask = 4'b1111;
      endcase
      wr_en = (beat_fire && !lat_rw && !misaligned) ? wr_mask : 4'b0000;
   end

   // Memory array: preload bytes and committed write beats; never reset.
   always_ff @(posedge main_clk) begin
      if (load_fire) begin
         mem[load_ptr] <= load_byte;
      end
      for (int i = 0; i < 4; i++) begin
         if (wr_en[i]) begin
            mem[byte_addr[i]] <= wr_byte[i];
         end
      end
   end

   // Handshake FSM with registered mfa/err/data_out and the preload pointer.
   always_ff @(posedge main_clk) begin
      if (reset) begin
         state    <= StIdle;
         wait_cnt <= 4'd0;
         mfa      <= 1'b0;
         err      <= 1'b0;
         data_out <= 32'h0;
         load_ptr <= '0;
         lat_rw   <= 1'b0;
         lat_size <= 2'b00;
         lat_addr <= '0;
         lat_data <= 32'h0;
      end else begin
         if (load_fire) begin
            load_ptr <= load_ptr + ADDR_WIDTH'(1);
         end
         unique case (state)
            StIdle: begin
               if (mov) begin
                  lat_rw   <= rw;
                  lat_size <= size;
                  lat_addr <= address;
                  lat_data <= data_in;
                  wait_cnt <= 4'(WAIT_CYCLES);
                  state    <= StWait;
               end
            end
            StWait, StWait2: begin
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end else begin
                  mfa <= 1'b1;
                  err <= misaligned;
                  if (misaligned) begin
                     data_out <= 32'h0;
                  end else if (lat_rw) begin
                     data_out <= rd_word;
                  end
                  // A misaligned doubleword is answered as one beat.
                  if ((state == StWait) && (lat_size == 2'b11) && !misaligned) begin
                     state <= StAck1;
                  end else begin
                     state <= StAck;
                  end
               end
            end
            StAck1: begin
               // One-cycle acknowledge of the first word; second-beat write
               // data is taken from the bus in this cycle.
               mfa      <= 1'b0;
               lat_data <= data_in;
               wait_cnt <= 4'(WAIT_CYCLES);
               state    <= StWait2;
            end
            StAck: begin
               if (!mov) begin
                  mfa   <= 1'b0;
                  err   <= 1'b0;
                  state <= StIdle;
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule
